// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner tags
// and the width of the IF starvation counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the arbiter, the fetch and load/store requesters,
// and the single memory port. The arbiter uses 'slave'; the outside world 'master'.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_stall;

  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  spurious_err;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_rvalid, if_rdata, if_stall,
    output d_rvalid, d_rdata, d_stall,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output spurious_err
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_rvalid, if_rdata, if_stall,
    input  d_rvalid, d_rdata, d_stall,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  spurious_err
  );

endinterface

// File: rtl/mem_port_arbiter_starve.sv
// Saturating count of DATA grants taken while IF is waiting; at_max_o tells
// the arbiter that IF must win the next grant.
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_d_i,
  input  logic grant_if_i,
  input  logic if_req_i,
  output logic at_max_o
);

  localparam logic [STARVE_CNT_W-1:0] MaxCnt = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!if_req_i || grant_if_i) begin
      cnt_d = '0;
    end else if (grant_d_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MaxCnt);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-ported memory,
// one transaction outstanding at a time, DATA first with an IF starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_port_arbiter_if.slave       bus_io
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                spurious_q, spurious_d;

  logic                grant_d;
  logic                grant_if;
  logic                at_max;

  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .grant_d_i  (grant_d),
    .grant_if_i (grant_if),
    .if_req_i   (bus_io.if_req),
    .at_max_o   (at_max)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_d     = 1'b0;
    grant_if    = 1'b0;
    spurious_d  = spurious_q | (bus_io.mem_rvalid && (state_q != WAIT));

    unique case (state_q)
      IDLE: begin
        if (bus_io.d_req && !(bus_io.if_req && at_max)) begin
          grant_d     = 1'b1;
          owner_d     = OWN_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus_io.d_we;
          mem_be_d    = bus_io.d_be;
          mem_addr_d  = bus_io.d_addr;
          mem_wdata_d = bus_io.d_wdata;
          state_d     = ISSUE;
        end else if (bus_io.if_req) begin
          // Fetches are always full-word reads.
          grant_if    = 1'b1;
          owner_d     = OWN_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = bus_io.if_addr;
          mem_wdata_d = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (bus_io.mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (bus_io.mem_rvalid) begin
          state_d = IDLE;
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus_io.mem_rdata;
          end else begin
            d_rvalid_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = bus_io.mem_rdata;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      spurious_q  <= spurious_d;
    end
  end

  // Stalls depend only on the live request and the registered response pulse.
  assign bus_io.if_stall     = bus_io.if_req && !if_rvalid_q;
  assign bus_io.d_stall      = bus_io.d_req && !d_rvalid_q;
  assign bus_io.if_rvalid    = if_rvalid_q;
  assign bus_io.if_rdata     = if_rdata_q;
  assign bus_io.d_rvalid     = d_rvalid_q;
  assign bus_io.d_rdata      = d_rdata_q;
  assign bus_io.mem_req      = mem_req_q;
  assign bus_io.mem_we       = mem_we_q;
  assign bus_io.mem_be       = mem_be_q;
  assign bus_io.mem_addr     = mem_addr_q;
  assign bus_io.mem_wdata    = mem_wdata_q;
  assign bus_io.spurious_err = spurious_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized phase, all compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int passCnt  = 0;
  int checkCnt = 0;

  // Requester and memory-responder stimulus state
  bit          ifReq, dReq, dWe;
  logic [3:0]  dBe;
  logic [31:0] ifAddr, dAddr, dWdata;
  bit          memReady, memRvalid;
  logic [31:0] memRdata, nextRdata;
  bit          useNextRdata, randMode, dRepeat;
  int          readyWait, respWait, cfgReady, cfgResp;

  // Reference model: one outstanding transaction record plus visible results
  bit          busy, accepted, ownerD;
  logic        expWe;
  logic [3:0]  expBe;
  logic [31:0] expAddr, expWdata;
  int          starve;
  bit          curIfRv, curDRv, expSpur;
  logic [31:0] expIfRdata, expDRdata;
  bit          sawIfRv, sawDRv;

  logic [31:0] grantQ[$];
  logic        prevMemReq;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt = checkCnt + 1;
    assert (obs === exp) passCnt = passCnt + 1;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic driveBus();
    bus.if_req     = ifReq;
    bus.if_addr    = ifAddr;
    bus.d_req      = dReq;
    bus.d_we       = dWe;
    bus.d_be       = dBe;
    bus.d_addr     = dAddr;
    bus.d_wdata    = dWdata;
    bus.mem_ready  = memReady;
    bus.mem_rvalid = memRvalid;
    bus.mem_rdata  = memRdata;
  endtask

  // One clock cycle: drive inputs, predict the edge, advance, compare.
  task automatic applyStimulus();
    bit grantIf, grantD, nIfRv, nDRv;
    driveBus();
    #1;
    checkOutput("if_stall", bus.if_stall, ifReq && !curIfRv);
    checkOutput("d_stall", bus.d_stall, dReq && !curDRv);
    grantIf = 0; grantD = 0; nIfRv = 0; nDRv = 0;
    if (memRvalid && !(busy && accepted)) expSpur = 1;
    if (!busy) begin
      if (ifReq && (starve == STARVE_MAX || !dReq)) grantIf = 1;
      else if (dReq) grantD = 1;
      if (grantIf || grantD) begin
        busy      = 1;
        accepted  = 0;
        ownerD    = grantD;
        expWe     = grantD ? dWe : 1'b0;
        expBe     = grantD ? dBe : 4'hF;
        expAddr   = grantD ? dAddr : ifAddr;
        expWdata  = grantD ? dWdata : 32'h0;
        readyWait = randMode ? int'($urandom_range(0, 3)) : cfgReady;
        respWait  = randMode ? int'($urandom_range(0, 3)) : cfgResp;
      end
    end else if (!accepted) begin
      if (memReady) accepted = 1;
    end else if (memRvalid) begin
      busy = 0;
      if (ownerD) begin
        nDRv = 1;
        if (!expWe) expDRdata = memRdata;
      end else begin
        nIfRv = 1;
        expIfRdata = memRdata;
      end
    end
    if (!ifReq || grantIf) starve = 0;
    else if (grantD) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;

    @(posedge clk);
    #1;
    curIfRv = nIfRv;
    curDRv  = nDRv;
    if (curIfRv) sawIfRv = 1;
    if (curDRv) sawDRv = 1;
    checkOutput("mem_req", bus.mem_req, busy && !accepted);
    if (busy && !accepted) begin
      checkOutput("mem_we", bus.mem_we, expWe);
      checkOutput("mem_be", bus.mem_be, expBe);
      checkOutput("mem_addr", bus.mem_addr, expAddr);
      checkOutput("mem_wdata", bus.mem_wdata, expWdata);
    end
    checkOutput("if_rvalid", bus.if_rvalid, curIfRv);
    checkOutput("d_rvalid", bus.d_rvalid, curDRv);
    checkOutput("if_rdata", bus.if_rdata, expIfRdata);
    checkOutput("d_rdata", bus.d_rdata, expDRdata);
    checkOutput("spurious_err", bus.spurious_err, expSpur);
    if (bus.mem_req === 1'b1 && prevMemReq !== 1'b1) grantQ.push_back(bus.mem_addr);
    prevMemReq = bus.mem_req;
  endtask

  // Requesters react to responses; the memory responder follows the model's transaction.
  task automatic planNext();
    if (curIfRv) ifReq = 0;
    if (curDRv) begin
      dReq = 0;
      if (dRepeat) begin
        dReq  = 1;
        dAddr = dAddr + 32'h4;
      end
    end
    if (randMode) begin
      if (!ifReq && $urandom_range(0, 1) == 1) begin
        ifReq  = 1;
        ifAddr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dReq && $urandom_range(0, 1) == 1) begin
        dReq   = 1;
        dWe    = $urandom_range(0, 1) == 1;
        dBe    = 4'($urandom);
        dAddr  = $urandom & 32'hFFFF_FFFC;
        dWdata = $urandom;
      end
    end
    memReady  = 0;
    memRvalid = 0;
    memRdata  = $urandom;
    if (busy && !accepted) begin
      if (readyWait == 0) memReady = 1;
      else readyWait = readyWait - 1;
    end else if (busy && accepted) begin
      if (respWait == 0) begin
        memRvalid = 1;
        if (useNextRdata) memRdata = nextRdata;
      end else begin
        respWait = respWait - 1;
      end
    end
  endtask

  task automatic doReset();
    ifReq = 0; dReq = 0; dWe = 0; dBe = '0; ifAddr = '0; dAddr = '0; dWdata = '0;
    memReady = 0; memRvalid = 0; memRdata = '0; dRepeat = 0;
    driveBus();
    rst = 1'b1;
    #2;
    busy = 0; accepted = 0; starve = 0; curIfRv = 0; curDRv = 0;
    expIfRdata = '0; expDRdata = '0; expSpur = 0;
    checkOutput("rst_mem_req", bus.mem_req, 1'b0);
    checkOutput("rst_mem_we", bus.mem_we, 1'b0);
    checkOutput("rst_mem_be", bus.mem_be, 4'h0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 32'h0);
    checkOutput("rst_if_rvalid", bus.if_rvalid, 1'b0);
    checkOutput("rst_d_rvalid", bus.d_rvalid, 1'b0);
    checkOutput("rst_if_rdata", bus.if_rdata, 32'h0);
    checkOutput("rst_d_rdata", bus.d_rdata, 32'h0);
    checkOutput("rst_spurious", bus.spurious_err, 1'b0);
    checkOutput("rst_if_stall", bus.if_stall, 1'b0);
    checkOutput("rst_d_stall", bus.d_stall, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    prevMemReq = 1'b0;
  endtask

  initial begin
    int n;
    int ifCycle;
    bit ok;
    randMode = 0; useNextRdata = 1; cfgReady = 0; cfgResp = 0;
    sawIfRv = 0; sawDRv = 0;

    $display("[TB] reset");
    doReset();

    // IF-only fetch: pulse expected three cycles after the request is sampled
    $display("[TB] IF-only fetch");
    ifReq = 1; ifAddr = 32'h100; nextRdata = 32'h0050_0093;
    n = 0; ifCycle = -1;
    while (ifCycle < 0 && n < 40) begin
      applyStimulus();
      n = n + 1;
      if (bus.if_rvalid === 1'b1) ifCycle = n;
      planNext();
    end
    checkOutput("t1_latency", 64'(ifCycle), 64'd3);
    checkOutput("t1_if_rdata", bus.if_rdata, 32'h0050_0093);

    // Simultaneous IF and DATA: DATA goes first
    $display("[TB] simultaneous requests");
    applyStimulus(); planNext();
    grantQ.delete(); sawIfRv = 0; sawDRv = 0;
    ifReq = 1; ifAddr = 32'h300; dReq = 1; dWe = 0; dBe = 4'hF; dAddr = 32'h2000; dWdata = '0;
    nextRdata = 32'hCAFE_0001;
    n = 0;
    while (!(sawIfRv && sawDRv) && n < 60) begin
      applyStimulus(); planNext(); n = n + 1;
      if (curDRv) nextRdata = 32'hCAFE_0002;
    end
    checkOutput("t2_done", sawIfRv && sawDRv, 1'b1);
    checkOutput("t2_grants", 64'(grantQ.size()), 64'd2);
    if (grantQ.size() >= 2) begin
      checkOutput("t2_first_grant", grantQ[0], 32'h2000);
      checkOutput("t2_second_grant", grantQ[1], 32'h300);
    end
    checkOutput("t2_d_rdata", bus.d_rdata, 32'hCAFE_0001);
    checkOutput("t2_if_rdata", bus.if_rdata, 32'hCAFE_0002);

    // Starvation guard: continuous DATA with IF waiting
    $display("[TB] starvation guard");
    applyStimulus(); planNext();
    grantQ.delete();
    dRepeat = 1; dReq = 1; dWe = 0; dBe = 4'hF; dAddr = 32'h4000;
    ifReq = 1; ifAddr = 32'h500; nextRdata = 32'h1111_2222;
    n = 0;
    while (grantQ.size() < 6 && n < 100) begin
      applyStimulus(); planNext(); n = n + 1;
    end
    checkOutput("t3_grants", 64'(grantQ.size()), 64'd6);
    if (grantQ.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        checkOutput($sformatf("t3_grant%0d_is_if", i), grantQ[i] == 32'h500, i == 4);
      end
    end
    dRepeat = 0;
    n = 0;
    while ((busy || ifReq || dReq) && n < 60) begin
      applyStimulus(); planNext(); n = n + 1;
    end
    checkOutput("t3_drained", busy || ifReq || dReq, 1'b0);

    // Store with a slow mem_ready: fields stable, d_rdata untouched
    $display("[TB] delayed store");
    sawDRv = 0; cfgReady = 3;
    dReq = 1; dWe = 1; dBe = 4'b0011; dAddr = 32'h3000; dWdata = 32'hDEAD_BEEF;
    nextRdata = 32'h5A5A_5A5A;
    n = 0;
    while (!sawDRv && n < 40) begin
      applyStimulus(); planNext(); n = n + 1;
    end
    checkOutput("t4_d_rvalid_seen", sawDRv, 1'b1);
    checkOutput("t4_d_rdata_kept", bus.d_rdata, 32'h1111_2222);
    cfgReady = 0;

    // Reset while waiting for the response; the late response is spurious
    $display("[TB] reset during WAIT");
    doReset();
    cfgResp = 3; ifReq = 1; ifAddr = 32'h600;
    n = 0;
    while (!(busy && accepted) && n < 20) begin
      applyStimulus(); planNext(); n = n + 1;
    end
    checkOutput("t5_reached_wait", busy && accepted, 1'b1);
    applyStimulus();
    doReset();
    memRvalid = 1; memRdata = 32'hBAD0_BAD0;
    applyStimulus();
    memRvalid = 0;
    checkOutput("t5_spurious", bus.spurious_err, 1'b1);
    cfgResp = 0; sawIfRv = 0; ifReq = 1; ifAddr = 32'h700; nextRdata = 32'h1234_5678;
    n = 0;
    while (!sawIfRv && n < 20) begin
      applyStimulus(); planNext(); n = n + 1;
    end
    checkOutput("t5_if_rdata", bus.if_rdata, 32'h1234_5678);

    // mem_rvalid while idle: sticky error until reset
    $display("[TB] spurious response in IDLE");
    doReset();
    memRvalid = 1; memRdata = 32'h0BAD_F00D;
    applyStimulus();
    memRvalid = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(); planNext();
    end
    checkOutput("t6_sticky", bus.spurious_err, 1'b1);
    doReset();

    // Randomized traffic against the model
    $display("[TB] random traffic");
    randMode = 1; useNextRdata = 0;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(); planNext();
    end
    randMode = 0;
    ifReq = ifReq && busy && !ownerD;
    dReq  = dReq && busy && ownerD;
    n = 0;
    while ((busy || ifReq || dReq) && n < 60) begin
      applyStimulus(); planNext(); n = n + 1;
    end
    checkOutput("t7_drained", busy || ifReq || dReq, 1'b0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch (IF) and load/store (DATA) in the pipelined RV32I core.
- Serialises requests with a single-outstanding-transaction FSM.
- DATA has priority, with a starvation guard for IF.
- Per-requester stall signals freeze the fetch and memory stages while their access is pending.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- STARVE_MAX, 4, number of consecutive DATA grants while IF waits before IF is forced in; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held with if_addr until if_rvalid.
- if_addr  in  ADDR_W  fetch address.
- if_rvalid  out  1  one-cycle pulse: if_rdata is valid.
- if_rdata  out  DATA_W  fetched instruction.
- if_stall  out  1  if_req && !if_rvalid.
- d_req  in  1  load/store request; fields held until d_rvalid.
- d_we  in  1  1 = store.
- d_be  in  DATA_W/8  byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rvalid  out  1  one-cycle pulse: load data valid, or store acknowledged.
- d_rdata  out  DATA_W  load data.
- d_stall  out  1  d_req && !d_rvalid.
- mem_req  out  1  request to memory; held until mem_ready.
- mem_we, mem_be, mem_addr, mem_wdata  out  1 / DATA_W/8 / ADDR_W / DATA_W  registered request fields.
- mem_ready  in  1  memory accepts request this cycle.
- mem_rvalid  in  1  response (read data or write ack).
- mem_rdata  in  DATA_W  read data.
- spurious_err  out  1  sticky: mem_rvalid seen while not in WAIT.

Behaviour:
- Reset (async, rst=1) clears: state=IDLE, mem_req=0, mem_* fields=0, if_rvalid=d_rvalid=0, if_rdata=d_rdata=0, starve_cnt=0, owner=IF, spurious_err=0.
- FSM states:
  - IDLE: if d_req or if_req, choose winner and latch its fields into mem_*. mem_req=1 next cycle; go to ISSUE.
  - ISSUE: mem_req stays 1 with stable fields. On mem_ready, mem_req=0 next cycle; go to WAIT.
  - WAIT: on mem_rvalid, latch mem_rdata into the owner's rdata and pulse the owner's rvalid for exactly the next cycle; go to IDLE.
- Winner selection: DATA wins, unless if_req && starve_cnt==STARVE_MAX, in which case IF wins.
- starve_cnt:
  - +1 on each DATA grant while if_req=1, saturating at STARVE_MAX.
  - Cleared on any IF grant, and on any cycle with if_req=0.
- mem_ready and mem_rvalid may arrive in the same cycle only in WAIT. A mem_rvalid during ISSUE is spurious.
- Latency: requests sampled in IDLE at cycle 0; mem_req rises at cycle 1. With mem_ready at cycle 1 and mem_rvalid at cycle 2, rvalid pulses at cycle 3. Minimum 3 cycles per access.
- After the rvalid pulse the FSM is back in IDLE, so the next grant happens in the same cycle as the pulse. Requesters drop or change req in that cycle.
- Requester deasserting req mid-transaction: the transaction still completes and rvalid still pulses. The requester ignores it.
- Store: d_rvalid pulses on the write ack. d_rdata is left unchanged.
- mem_rvalid in IDLE or ISSUE: ignored, and spurious_err is set (cleared only by rst).
- rst mid-transaction: state is abandoned immediately and no rvalid is produced. The memory controller is reset on the same rst.
- if_stall and d_stall are combinational from req and the registered rvalid. No combinational path exists from mem_* inputs to any output.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, ISSUE, WAIT}.
  - typedef enum logic owner_t {OWN_IF, OWN_D}.
  - Constant STARVE_CNT_W = 4.
- Natural sub-module: arb_starve_counter, the saturating counter with clear. Its input is grant_d / grant_if / if_req; its output is at_max.
- FSM and datapath registers stay in mem_port_arbiter.

Test Plan:
- IF only, if_addr=0x100, memory returns 0x00500093 one cycle after mem_ready → mem_req at cycle 1 with mem_addr=0x100, if_rvalid pulse at cycle 3 with if_rdata=0x00500093, if_stall=1 during cycles 0–2.
- Simultaneous if_req and d_req (load, 0x2000) → DATA granted first. IF is granted on the next IDLE with mem_addr=if_addr. d_rdata and if_rdata go to the correct ports.
- d_req held continuously with if_req=1, STARVE_MAX=4 → grant sequence D,D,D,D,IF,D. starve_cnt returns to 0 after the IF grant.
- Store d_we=1, d_be=4'b0011, d_wdata=0xDEADBEEF, mem_ready delayed 3 cycles → mem_* fields stable while mem_req=1, d_rvalid pulses after the ack, d_rdata unchanged.
- rst asserted in WAIT, then mem_rvalid arrives after release → no rvalid pulse, spurious_err=1, next if_req serviced normally.
- mem_rvalid injected while IDLE → spurious_err=1 and stays 1 until rst. No rvalid pulse.
